lsu_rmw: RTL

- Load/store unit between the core execute stage and the data port of `memory_sim`.
- Converts RV32I byte, halfword and word loads and stores into word-only accesses on the data port. That port has no byte enables.
- Sub-word stores use a read-modify-write sequence.
- Alignment is checked; misaligned and illegal requests complete with an error and no memory access.

---
 rtl/lsu_rmw_if.sv | 30 +++
 rtl/lsu_rmw.sv | 131 +++++++++++++
 2 files changed

// File: rtl/lsu_rmw_if.sv
// Core request/response and word-only data-port signals of the load/store unit.
// master = core + memory side, slave = lsu_rmw.
interface lsu_rmw_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_we;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, d_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, d_addr, d_wdata, d_we
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, d_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, d_addr, d_wdata, d_we
  );
endinterface

// File: rtl/lsu_rmw.sv
// RV32I load/store unit: byte/half/word accesses mapped onto a word-only data port,
// sub-word stores by read-modify-write; misaligned/illegal requests answer with err.
module lsu_rmw #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_rmw_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_q;
  logic [15:0]       wdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] d_addr_q;
  logic [DATA_W-1:0] d_wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              req_err;
  logic [DATA_W-1:0] byte_sh;
  logic [DATA_W-1:0] half_sh;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] merged;

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    req_err = 1'b0;
    if (!(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
      req_err = 1'b1;
    if (bus.req_we && bus.req_funct3[2])
      req_err = 1'b1;
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
      req_err = 1'b1;
    if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
      req_err = 1'b1;
  end

  // Lane extraction for loads; funct3[2] selects zero- instead of sign-extension.
  always_comb begin
    byte_sh = bus.d_rdata >> {addr_q, 3'b000};
    half_sh = bus.d_rdata >> {addr_q[1], 4'b0000};
    case (funct3_q[1:0])
      2'b00:   ld_val = {{24{~funct3_q[2] & byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   ld_val = {{16{~funct3_q[2] & half_sh[15]}}, half_sh[15:0]};
      default: ld_val = bus.d_rdata;
    endcase
  end

  always_comb begin
    merged = bus.d_rdata;
    if (funct3_q[1:0] == 2'b00)
      merged[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                       state_d = RESP;
          else if (!bus.req_we)              state_d = LOAD;
          else if (bus.req_funct3 == 3'b010) state_d = WRITE;
          else                               state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr[1:0];
            wdata_q  <= bus.req_wdata[15:0];
            err_q    <= req_err;
            rdata_q  <= '0;
            // Errors leave the data port untouched.
            if (!req_err) begin
              d_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              if (bus.req_we && bus.req_funct3 == 3'b010)
                d_wdata_q <= bus.req_wdata;
            end
          end
        end
        LOAD:    rdata_q   <= ld_val;
        RMW_RD:  d_wdata_q <= merged;
        default: ;
      endcase
    end
  end

  // Gating with rst_n keeps a write or response from escaping in the reset cycle.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.d_we       = (state_q == WRITE) && rst_n;
    bus.resp_valid = (state_q == RESP) && rst_n;
    bus.resp_err   = bus.resp_valid && err_q;
    bus.resp_rdata = rdata_q;
    bus.d_addr     = d_addr_q;
    bus.d_wdata    = d_wdata_q;
  end

endmodule
